// File: rtl/vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module  : vga_line_fetch
// Brief   : Fetches framebuffer lines over a req/gnt read bus into the colbuf.
// Revision: 1.0
// ============================================================================
module vga_line_fetch #(
    parameter int HOR_PXL         = 800,
    parameter int VER_PXL         = 600,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        sys_pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] fb_base,
    input  logic        frame_int,
    input  logic        buffill_int,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        colbuf_we,
    output logic [9:0]  colbuf_waddr,
    output logic [31:0] colbuf_wdata,
    output logic        busy,
    output logic        line_done,
    output logic        underrun
);

    localparam int                 CNT_W      = 11;
    localparam int                 LINE_W     = $clog2(VER_PXL + 1);
    localparam logic [CNT_W-1:0]   HOR_CNT    = CNT_W'(HOR_PXL);
    localparam logic [CNT_W-1:0]   HOR_LAST   = CNT_W'(HOR_PXL - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [LINE_W-1:0]  VER_CNT    = LINE_W'(VER_PXL);
    localparam logic [LINE_W-1:0]  LINE_ONE   = LINE_W'(1);
    localparam logic [3:0]         MAX_OUT    = 4'(MAX_OUTSTANDING);
    localparam logic [31:0]        LINE_BYTES = 32'(HOR_PXL * 4);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              frame_d;
    logic              fill_d;
    logic [CNT_W-1:0]  req_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic [3:0]        outstanding;
    logic [LINE_W-1:0] line_cnt;
    logic [31:0]       line_addr;

    logic frame_rise;
    logic fill_rise;
    logic start;
    logic grant;
    logic accept;
    logic write;
    logic line_complete;

    assign frame_rise    = frame_int & ~frame_d;
    assign fill_rise     = buffill_int & ~fill_d;
    // A coincident frame rise rewinds line_cnt first, so line 0 is always allowed.
    assign start         = fill_rise && (state == ST_IDLE) && enable &&
                           (frame_rise || (line_cnt < VER_CNT));
    assign grant         = mem_req & mem_gnt;
    assign accept        = mem_rvalid && (outstanding != 4'd0);
    assign write         = accept && ((state == ST_FETCH) || (state == ST_DRAIN));
    assign line_complete = (state == ST_DRAIN) && (wr_cnt == HOR_CNT);

    always_ff @(posedge sys_pclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (frame_rise)                          state_nxt = ST_ABORT;
                else if (grant && (req_cnt == HOR_LAST)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frame_rise)         state_nxt = ST_ABORT;
                else if (line_complete) state_nxt = ST_IDLE;
            end
            default: begin
                if (outstanding == 4'd0) state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = 32'd0;
        busy     = (state != ST_IDLE);
        if ((state == ST_FETCH) && (req_cnt < HOR_CNT) && (outstanding < MAX_OUT)) begin
            mem_req  = 1'b1;
            mem_addr = line_addr + (32'(req_cnt) << 2);
        end
    end

    always_ff @(posedge sys_pclk or posedge rst) begin
        if (rst) begin
            frame_d      <= 1'b0;
            fill_d       <= 1'b0;
            req_cnt      <= '0;
            wr_cnt       <= '0;
            outstanding  <= 4'd0;
            line_cnt     <= '0;
            line_addr    <= 32'd0;
            colbuf_we    <= 1'b0;
            colbuf_waddr <= 10'd0;
            colbuf_wdata <= 32'd0;
            line_done    <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_d   <= frame_int;
            fill_d    <= buffill_int;
            line_done <= line_complete && !frame_rise;
            underrun  <= fill_rise && (state != ST_IDLE) && !frame_rise;
            colbuf_we <= write;
            if (write) begin
                colbuf_waddr <= wr_cnt[9:0];
                colbuf_wdata <= mem_rdata;
            end

            if (start) begin
                req_cnt     <= '0;
                wr_cnt      <= '0;
                outstanding <= 4'd0;
            end else begin
                if (grant)  req_cnt <= req_cnt + CNT_ONE;
                if (accept) wr_cnt  <= wr_cnt + CNT_ONE;
                if (grant && !accept)      outstanding <= outstanding + 4'd1;
                else if (!grant && accept) outstanding <= outstanding - 4'd1;
            end

            if (frame_rise) begin
                line_cnt  <= '0;
                line_addr <= fb_base;
            end else if (line_complete) begin
                line_cnt  <= line_cnt + LINE_ONE;
                line_addr <= line_addr + LINE_BYTES;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_line_fetch
// Brief   : Randomized self-checking bench with an in-order latency memory model.
// Revision: 1.0
// ============================================================================
module tb_vga_line_fetch;

    localparam int HP = 800;
    localparam int VP = 4;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] fb_base = 32'd0;
    logic        frame_int = 1'b0;
    logic        buffill_int = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        colbuf_we;
    logic [9:0]  colbuf_waddr;
    logic [31:0] colbuf_wdata;
    logic        busy;
    logic        line_done;
    logic        underrun;

    vga_line_fetch #(.HOR_PXL(HP), .VER_PXL(VP), .MAX_OUTSTANDING(MO)) dut (
        .sys_pclk(clk), .rst(rst), .enable(enable), .fb_base(fb_base),
        .frame_int(frame_int), .buffill_int(buffill_int),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .colbuf_we(colbuf_we), .colbuf_waddr(colbuf_waddr), .colbuf_wdata(colbuf_wdata),
        .busy(busy), .line_done(line_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model knobs and observation logs
    int          gnt_pct = 100;
    int          lat = 2;
    int          gnt_budget = -1;
    logic [31:0] salt = 32'd0;
    int          cyc = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_log[$];
    logic [9:0]  wlog_a[$];
    logic [31:0] wlog_d[$];
    int          n_done, n_under, n_unstable, max_out;
    bit          hold, g, frame_prev;
    logic [31:0] hold_addr;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            hold       = 1'b0;
        end else begin
            if (colbuf_we) begin
                wlog_a.push_back(colbuf_waddr);
                wlog_d.push_back(colbuf_wdata);
            end
            if (line_done) n_done++;
            if (underrun)  n_under++;
            if (hold && !(frame_int && !frame_prev) &&
                (mem_req !== 1'b1 || mem_addr !== hold_addr)) n_unstable++;
            g = (gnt_budget != 0) && ($urandom_range(0, 99) < gnt_pct);
            mem_gnt = g;
            if (mem_req && g) begin
                pend_addr.push_back(mem_addr);
                pend_due.push_back(cyc + lat);
                req_log.push_back(mem_addr);
                if (gnt_budget > 0) gnt_budget--;
            end
            hold      = mem_req && !g;
            hold_addr = mem_addr;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_addr[0] ^ salt;
                pend_addr.pop_front();
                pend_due.pop_front();
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            if (pend_addr.size() > max_out) max_out = pend_addr.size();
        end
        frame_prev = frame_int;
    end

    task automatic clear_logs();
        req_log.delete();
        wlog_a.delete();
        wlog_d.delete();
        n_done = 0; n_under = 0; n_unstable = 0; max_out = 0;
    endtask

    task automatic pulse_fill();
        buffill_int = 1'b1;
        repeat (2) @(negedge clk);
        #1 buffill_int = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic frame_pulse(input logic [31:0] b);
        fb_base   = b;
        frame_int = 1'b1;
        repeat (2) @(negedge clk);
        #1 frame_int = 1'b0;
        @(negedge clk); #1;
    endtask

    // kind: 0 line_done count, 1 write count, 2 request count, 3 idle
    function automatic bit reached(input int kind, input int target);
        case (kind)
            0:       return n_done >= target;
            1:       return wlog_a.size() >= target;
            2:       return req_log.size() >= target;
            default: return busy === 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int kind, input int target, input int budget, output bit to);
        for (int i = 0; i < budget && !reached(kind, target); i++) begin
            @(negedge clk); #1;
        end
        to = !reached(kind, target);
    endtask

    // Counts writes that differ from a full line fetched from base with the current salt.
    function automatic int line_bad(input logic [31:0] base);
        int bad = 0;
        if (wlog_a.size() != HP || req_log.size() < HP) return HP + 1;
        for (int i = 0; i < HP; i++) begin
            if (wlog_a[i] !== 10'(i) || wlog_d[i] !== ((base + 32'(4 * i)) ^ salt) ||
                req_log[i] !== base + 32'(4 * i)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({mem_req, mem_addr, colbuf_we, colbuf_waddr, colbuf_wdata, busy, line_done, underrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: mem_req=%b mem_addr=%h we=%b busy=%b, need all 0", mem_req, mem_addr, colbuf_we, busy);
        end
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_zero_wait();
        bit to;
        int bad;
        enable = 1'b1; gnt_pct = 100; lat = 2; salt = 32'd0;
        clear_logs();
        fb_base = 32'h1000_0000; frame_int = 1'b1; buffill_int = 1'b1;
        repeat (2) @(negedge clk);
        #1 frame_int = 1'b0; buffill_int = 1'b0;
        wait_for(0, 1, 3000, to);
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        if (to) begin n_fail++; $display("FAIL zw_timeout: line_done count %0d, need 1", n_done); end
        bad = line_bad(32'h1000_0000);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL zw_line: %0d bad of %0d writes, need 0 bad of %0d", bad, wlog_a.size(), HP); end
        n_tests++;
        if (n_done != 1) begin n_fail++; $display("FAIL zw_done_count: %0d, need 1", n_done); end
        clear_logs();
        pulse_fill();
        wait_for(0, 1, 3000, to);
        n_tests++;
        if (to || req_log.size() == 0 || req_log[0] !== 32'h1000_0C80) begin
            n_fail++;
            $display("FAIL zw_next_line_addr: timeout=%0d first=%h, need 10000c80", to, req_log.size() ? req_log[0] : 32'hx);
        end
        bad = line_bad(32'h1000_0C80);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL zw_line2: %0d bad writes, need 0", bad); end
        n_tests++;
        if (max_out > MO) begin n_fail++; $display("FAIL zw_outstanding: %0d, need <= %0d", max_out, MO); end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        salt = $urandom;
        frame_pulse(base);
        gnt_pct = 30; lat = 10;
        clear_logs();
        pulse_fill();
        wait_for(0, 1, 6000, to);
        n_tests++;
        if (to) begin n_fail++; $display("FAIL bp_timeout: line_done count %0d, need 1", n_done); end
        n_tests++;
        if (n_unstable != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable ungranted cycles, need 0", n_unstable); end
        n_tests++;
        if (max_out > MO) begin n_fail++; $display("FAIL bp_outstanding: %0d, need <= %0d", max_out, MO); end
        bad = line_bad(base);
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_line: %0d bad writes, need 0 (base %h)", bad, base); end
        gnt_pct = 100;
    endtask

    task automatic test_underrun();
        bit to, to2;
        int bad;
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        salt = $urandom;
        lat = 3;
        frame_pulse(base);
        clear_logs();
        pulse_fill();
        wait_for(1, 100, 2000, to);
        pulse_fill();
        wait_for(0, 1, 3000, to2);
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        if (to || to2) begin n_fail++; $display("FAIL ur_timeout: writes=%0d done=%0d, need 800 and 1", wlog_a.size(), n_done); end
        n_tests++;
        if (n_under != 1) begin n_fail++; $display("FAIL ur_pulses: %0d underrun pulses, need 1", n_under); end
        bad = line_bad(base);
        n_tests++;
        if (bad != 0 || req_log.size() != HP) begin n_fail++; $display("FAIL ur_line: %0d bad, %0d requests, need 0 and %0d", bad, req_log.size(), HP); end
        n_tests++;
        if (n_done != 1) begin n_fail++; $display("FAIL ur_done_count: %0d, need 1", n_done); end
    endtask

    task automatic test_abort();
        bit to;
        int bad;
        logic [31:0] b1, b2;
        b1 = $urandom & 32'hFFFF_FFFC;
        b2 = $urandom & 32'hFFFF_FFFC;
        salt = $urandom;
        frame_pulse(b1);
        clear_logs();
        gnt_budget = 3; lat = 40;
        pulse_fill();
        wait_for(2, 3, 200, to);
        repeat (5) @(negedge clk);
        #1;
        frame_pulse(b2);
        gnt_budget = -1;
        wait_for(3, 0, 300, to);
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        if (to || busy !== 1'b0) begin n_fail++; $display("FAIL ab_idle: busy=%b, need 0", busy); end
        n_tests++;
        if (req_log.size() != 3) begin n_fail++; $display("FAIL ab_requests: %0d requests, need 3", req_log.size()); end
        n_tests++;
        if (wlog_a.size() != 0 || n_done != 0) begin n_fail++; $display("FAIL ab_writes: %0d writes %0d done, need 0 and 0", wlog_a.size(), n_done); end
        lat = 2;
        clear_logs();
        pulse_fill();
        wait_for(0, 1, 3000, to);
        bad = line_bad(b2);
        n_tests++;
        if (to || bad != 0) begin n_fail++; $display("FAIL ab_refetch: timeout=%0d bad=%0d, need line from %h at addr 0", to, bad, b2); end
    endtask

    task automatic test_frame_end();
        bit to;
        int tos = 0;
        int bad = 0;
        int idx;
        logic [31:0] base;
        base = $urandom & 32'hFFFF_FFFC;
        frame_pulse(base);
        clear_logs();
        enable = 1'b0;
        pulse_fill();
        repeat (5) @(negedge clk);
        #1;
        n_tests++;
        if (req_log.size() != 0 || n_under != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fe_disabled: %0d requests underrun=%0d busy=%b, need 0 0 0", req_log.size(), n_under, busy);
        end
        enable = 1'b1;
        for (int k = 0; k < VP; k++) begin
            idx = req_log.size();
            pulse_fill();
            wait_for(0, k + 1, 3000, to);
            if (to) tos++;
            if (req_log.size() <= idx || req_log[idx] !== base + 32'(k * HP * 4)) bad++;
        end
        n_tests++;
        if (tos != 0 || bad != 0 || n_done != VP) begin
            n_fail++;
            $display("FAIL fe_lines: timeouts=%0d bad_starts=%0d done=%0d, need 0 0 %0d", tos, bad, n_done, VP);
        end
        pulse_fill();
        repeat (20) @(negedge clk);
        #1;
        n_tests++;
        if (req_log.size() != VP * HP || n_under != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fe_ignored: %0d requests underrun=%0d busy=%b, need %0d 0 0", req_log.size(), n_under, busy, VP * HP);
        end
        frame_pulse(base);
        pulse_fill();
        wait_for(0, VP + 1, 3000, to);
        n_tests++;
        if (to || req_log.size() <= VP * HP || req_log[VP * HP] !== base) begin
            n_fail++;
            $display("FAIL fe_restart: timeout=%0d requests=%0d, need restart from %h", to, req_log.size(), base);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_logs();
        pulse_fill();
        wait_for(1, 50, 2000, to);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({mem_req, mem_addr, colbuf_we, colbuf_waddr, colbuf_wdata, busy, line_done, underrun} !== '0) begin
            n_fail++;
            $display("FAIL rm_async: mem_req=%b we=%b busy=%b, need all 0 at once", mem_req, colbuf_we, busy);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || dut.line_cnt !== '0) begin
            n_fail++;
            $display("FAIL rm_state: busy=%b line_cnt=%0d, need 0 0", busy, dut.line_cnt);
        end
        clear_logs();
        pulse_fill();
        wait_for(0, 1, 3000, to);
        n_tests++;
        if (to || req_log.size() == 0 || req_log[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL rm_refetch: timeout=%0d requests=%0d, need fetch from 0", to, req_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_underrun();
        test_abort();
        test_frame_end();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
